// File: rtl/csr_pkg.sv
// Shared definitions for the CSR execution sequencer: CSR addresses, funct3 encodings,
// sequencer states and the list of CSR addresses that csr_file implements.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [2:0] {
        F3_PRIV = 3'b000,
        F3_RW   = 3'b001,
        F3_RS   = 3'b010,
        F3_RC   = 3'b011,
        F3_RSV  = 3'b100,
        F3_RWI  = 3'b101,
        F3_RSI  = 3'b110,
        F3_RCI  = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_TRAP,
        ST_RESP
    } state_e;

    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MVENDORID, CSR_MARCHID: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational read-modify-write datapath: merges the old CSR value with the source
// operand according to funct3 and decides whether csr_file is actually written.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] old,
    output logic [XLEN-1:0] wdata,
    output logic            write_en
);

    logic [XLEN-1:0] src;

    // Immediate forms use the rs1 field itself as a zero-extended 5-bit operand.
    assign src = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;

    always_comb begin
        wdata    = old;
        write_en = 1'b0;
        case (funct3_e'(funct3))
            F3_RW, F3_RWI: begin
                wdata    = src;
                write_en = 1'b1;
            end
            F3_RS, F3_RSI: begin
                wdata    = old | src;
                write_en = (rs1_idx != 5'd0);
            end
            F3_RC, F3_RCI: begin
                wdata    = old & ~src;
                write_en = (rs1_idx != 5'd0);
            end
            default: begin
                wdata    = old;
                write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// Sequencer in front of csr_file: runs CSR read-modify-write or ECALL/MRET trap handshakes,
// one instruction at a time. Optional macro CSR_ILLEGAL_CHECK_EN enables illegal-instruction traps.
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_csr,
    input  logic [4:0]        req_rs1_idx,
    input  logic [XLEN-1:0]   req_rs1_data,
    input  logic [XLEN-1:0]   req_pc,
    input  logic              req_ecall,
    input  logic              req_mret,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_write,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic [XLEN-1:0]   pc,
    output logic              is_ecall,
    output logic              is_mret,
    input  logic [XLEN-1:0]   mtvec_in,
    input  logic [XLEN-1:0]   mepc_in,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rd_data,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal
);

    state_e            state_reg, state_next;
    logic              ecall_reg;
    logic              mret_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [4:0]        idx_reg;
    logic [XLEN-1:0]   data_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   old_reg;
    logic [XLEN-1:0]   redirect_pc_reg;

    logic [XLEN-1:0]   alu_wdata;
    logic              alu_write_en;
    logic              illegal_w;
    logic              trap_w;
    logic              rd_zero_w;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3   (funct3_reg),
        .rs1_idx  (idx_reg),
        .rs1_data (data_reg),
        .old      (old_reg),
        .wdata    (alu_wdata),
        .write_en (alu_write_en)
    );

`ifdef CSR_ILLEGAL_CHECK_EN
    logic illegal_reg;
    logic illegal_next;
    logic would_write;

    // Decided at accept time: everything it depends on is in the request itself.
    assign would_write  = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
    assign illegal_next = !(req_ecall || req_mret) &&
                          ((req_funct3[1:0] == 2'b00) ||
                           !csr_implemented(req_csr) ||
                           (would_write && (req_csr[11:10] == 2'b11)));
    assign illegal_w    = illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && req_valid) begin
            illegal_reg <= illegal_next;
        end
    end
`else
    assign illegal_w = 1'b0;
`endif

    assign trap_w    = ecall_reg | mret_reg;
    assign rd_zero_w = trap_w | illegal_w | (funct3_reg[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            ecall_reg       <= 1'b0;
            mret_reg        <= 1'b0;
            funct3_reg      <= '0;
            addr_reg        <= '0;
            idx_reg         <= '0;
            data_reg        <= '0;
            pc_reg          <= '0;
            old_reg         <= '0;
            redirect_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                ecall_reg  <= req_ecall;
                mret_reg   <= req_mret & ~req_ecall;
                funct3_reg <= req_funct3;
                addr_reg   <= req_csr;
                idx_reg    <= req_rs1_idx;
                data_reg   <= req_rs1_data;
                pc_reg     <= req_pc;
            end
            if (state_reg == ST_READ) begin
                old_reg <= csr_rdata;
            end
            // Illegal ops redirect to mtvec, sampled in WRITE; traps pick their target in TRAP.
            if (state_reg == ST_WRITE) begin
                redirect_pc_reg <= mtvec_in;
            end
            if (state_reg == ST_TRAP) begin
                redirect_pc_reg <= ecall_reg ? mtvec_in : mepc_in;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        req_ready      = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        csr_write      = 1'b0;
        pc             = '0;
        is_ecall       = 1'b0;
        is_mret        = 1'b0;
        resp_valid     = 1'b0;
        resp_rd_data   = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        illegal        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (req_ecall || req_mret) ? ST_TRAP : ST_READ;
                end
            end
            ST_READ: begin
                csr_addr   = addr_reg;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                csr_addr   = addr_reg;
                csr_wdata  = alu_wdata;
                csr_write  = alu_write_en & ~illegal_w;
                state_next = ST_RESP;
            end
            ST_TRAP: begin
                if (ecall_reg) begin
                    is_ecall = 1'b1;
                    pc       = pc_reg;
                end else begin
                    is_mret = 1'b1;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid     = 1'b1;
                resp_rd_data   = rd_zero_w ? '0 : old_reg;
                redirect_valid = trap_w | illegal_w;
                redirect_pc    = (trap_w | illegal_w) ? redirect_pc_reg : '0;
                illegal        = illegal_w;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // A reset landing mid-operation must not leak a write, pulse or response that cycle.
        if (rst) begin
            state_next     = ST_IDLE;
            csr_write      = 1'b0;
            is_ecall       = 1'b0;
            is_mret        = 1'b0;
            resp_valid     = 1'b0;
            redirect_valid = 1'b0;
            illegal        = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Randomized bench for csr_exec_unit: a small csr_file stand-in plus an instruction-level
// reference model that predicts rd, redirect, latency, pulses and resulting CSR contents.
module tb_csr_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic [31:0] req_pc;
    logic        req_ecall;
    logic        req_mret;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_write;
    logic [31:0] csr_rdata;
    logic [31:0] pc;
    logic        is_ecall;
    logic        is_mret;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        resp_valid;
    logic [31:0] resp_rd_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;
    int n_op  = 0;
    int wr_cnt = 0, ec_cnt = 0, mr_cnt = 0, ov_cnt = 0;

    logic [31:0] mem     [0:8];
    logic [31:0] ref_mem [0:8];
    logic [11:0] pool    [0:9];

    always #5 clk = ~clk;

    csr_exec_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_csr(req_csr), .req_rs1_idx(req_rs1_idx),
        .req_rs1_data(req_rs1_data), .req_pc(req_pc), .req_ecall(req_ecall),
        .req_mret(req_mret), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_write(csr_write), .csr_rdata(csr_rdata), .pc(pc), .is_ecall(is_ecall),
        .is_mret(is_mret), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .resp_valid(resp_valid), .resp_rd_data(resp_rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .illegal(illegal)
    );

    function automatic int idx_of(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            12'hB00: return 4;
            12'hB80: return 5;
            12'hF11: return 6;
            12'hF12: return 7;
            default: return 8;
        endcase
    endfunction

    // csr_file stand-in: combinational read, ecall has priority over a CSR write.
    always_comb csr_rdata = mem[idx_of(csr_addr)];
    assign mtvec_in = mem[1];
    assign mepc_in  = mem[2];

    always @(posedge clk) begin
        if (is_ecall) begin
            mem[2] <= pc;
            mem[3] <= 32'd11;
        end else if (csr_write && idx_of(csr_addr) != 8 && csr_addr[11:10] != 2'b11) begin
            mem[idx_of(csr_addr)] <= csr_wdata;
        end
    end

    always @(posedge clk) begin
        if (csr_write)             wr_cnt <= wr_cnt + 1;
        if (is_ecall)              ec_cnt <= ec_cnt + 1;
        if (is_mret)               mr_cnt <= mr_cnt + 1;
        if (csr_write && is_ecall) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input bit ec, input bit mr, input logic [2:0] f3, input logic [11:0] a,
                         input logic [4:0] idx, input logic [31:0] d, input logic [31:0] p);
        logic [31:0] src, old, nv, e_rd, e_rpc, g_rd, g_rpc;
        logic [1:0]  op;
        bit          e_rv, ill, wr, g_rv, g_ill;
        int          lat, e_lat, w0, e0, m0, o0, k, ai;
        ai    = idx_of(a);
        e_rd  = '0;
        e_rpc = '0;
        e_rv  = 1'b0;
        ill   = 1'b0;
        wr    = 1'b0;
        nv    = '0;
        e_lat = (ec || mr) ? 2 : 3;
        if (ec) begin
            e_rv = 1'b1; e_rpc = ref_mem[1];
        end else if (mr) begin
            e_rv = 1'b1; e_rpc = ref_mem[2];
        end else begin
            op  = f3[1:0];
            src = f3[2] ? {27'd0, idx} : d;
            old = ref_mem[ai];
            wr  = (op == 2'b01) || (op != 2'b00 && idx != 5'd0);
            nv  = (op == 2'b01) ? src : (op == 2'b10) ? (old | src) : (old & ~src);
`ifdef CSR_ILLEGAL_CHECK_EN
            ill = (op == 2'b00) || (ai == 8) || (wr && a[11:10] == 2'b11);
`endif
            if (ill) begin
                wr = 1'b0; e_rv = 1'b1; e_rpc = ref_mem[1];
            end else if (op != 2'b00) begin
                e_rd = old;
            end
        end

        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_ecall = ec; req_mret = mr; req_funct3 = f3; req_csr = a;
        req_rs1_idx = idx; req_rs1_data = d; req_pc = p;
        w0 = wr_cnt; e0 = ec_cnt; m0 = mr_cnt; o0 = ov_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; g_rd = '0; g_rpc = '0; g_rv = 1'b0; g_ill = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; g_rd = resp_rd_data; g_rv = redirect_valid;
                g_rpc = redirect_pc; g_ill = illegal;
            end
        end
        check("latency", lat, e_lat);
        check("rd_data", g_rd, e_rd);
        check("redirect_valid", {31'd0, g_rv}, {31'd0, e_rv});
        if (e_rv) check("redirect_pc", g_rpc, e_rpc);
        check("illegal", {31'd0, g_ill}, {31'd0, ill});
        check("write_count", wr_cnt - w0, {31'd0, wr});
        check("ecall_pulses", ec_cnt - e0, {31'd0, ec});
        check("mret_pulses", mr_cnt - m0, {31'd0, (mr && !ec)});
        check("write_ecall_overlap", ov_cnt - o0, 32'd0);

        if (ec) begin
            ref_mem[2] = p;
            ref_mem[3] = 32'd11;
        end else if (!mr && wr && ai != 8 && a[11:10] != 2'b11) begin
            ref_mem[ai] = nv;
        end
        if (ec || mr) begin
            check("mepc", mem[2], ref_mem[2]);
            check("mcause", mem[3], ref_mem[3]);
        end else begin
            check("csr_value", mem[ai], ref_mem[ai]);
        end
        n_op++;
        $display("op %0d: ec=%0d mr=%0d f3=%0d csr=%h idx=%0d rd=%h redir=%0d/%h ill=%0d lat=%0d",
                 n_op, ec, mr, f3, a, idx, g_rd, g_rv, g_rpc, g_ill, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        bit ec, mr;
        int r;
        pool[0] = 12'h300; pool[1] = 12'h305; pool[2] = 12'h341; pool[3] = 12'h342;
        pool[4] = 12'hB00; pool[5] = 12'hB80; pool[6] = 12'hF11; pool[7] = 12'hF12;
        pool[8] = 12'h7C0; pool[9] = 12'h001;
        for (int i = 0; i < 9; i++) mem[i] = '0;
        mem[0] = 32'h0000_1800;
        mem[6] = 32'h7973_7978;
        for (int i = 0; i < 9; i++) ref_mem[i] = mem[i];

        rst = 1'b1; req_valid = 1'b0; req_ecall = 1'b0; req_mret = 1'b0;
        req_funct3 = '0; req_csr = '0; req_rs1_idx = '0; req_rs1_data = '0; req_pc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_csr_write", {31'd0, csr_write}, 32'd0);
        check("reset_is_ecall", {31'd0, is_ecall}, 32'd0);
        check("reset_redirect", {31'd0, redirect_valid}, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);

        do_op(0, 0, 3'b001, 12'h305, 5'd5, 32'h0000_0040, 32'h8000_0000);
        do_op(0, 0, 3'b010, 12'h300, 5'd1, 32'h0000_0008, 32'h8000_0004);
        do_op(0, 0, 3'b111, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h8000_0008);
        do_op(1, 0, 3'b000, 12'h000, 5'd0, 32'h0,         32'h8000_0010);
        do_op(0, 0, 3'b001, 12'h341, 5'd7, 32'h8000_0014, 32'h0000_0040);
        do_op(0, 1, 3'b000, 12'h302, 5'd0, 32'h0,         32'h0000_0050);
        do_op(0, 0, 3'b001, 12'hF11, 5'd3, 32'h1234_5678, 32'h8000_0018);
        do_op(0, 0, 3'b000, 12'h300, 5'd2, 32'h5555_5555, 32'h8000_001C);
        do_op(1, 1, 3'b000, 12'h000, 5'd0, 32'h0,         32'h8000_0020);

        // Reset during the WRITE cycle must drop the write and the response.
        @(negedge clk);
        req_valid = 1'b1; req_ecall = 1'b0; req_mret = 1'b0; req_funct3 = 3'b001;
        req_csr = 12'h305; req_rs1_idx = 5'd9; req_rs1_data = 32'hDEAD_0000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("midop_rst_write", {31'd0, csr_write}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        @(negedge clk);
        check("midop_rst_ready", {31'd0, req_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        check("midop_rst_no_resp", seen, 0);
        check("midop_rst_mtvec", mem[1], ref_mem[1]);
        $display("op reset-in-WRITE: mtvec=%h resp_seen=%0d", mem[1], seen);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            ec = (r == 0);
            mr = (r == 1) || (r == 0 && $urandom_range(0, 1) == 1);
            do_op(ec, mr, 3'($urandom_range(0, 7)), pool[$urandom_range(0, 9)],
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                  $urandom, {$urandom} & 32'hFFFF_FFFC);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
